// File: rtl/alu_bist_pkg.sv
// Shared types and constants for the 4-bit ALU built-in self-test checker.
package alu_bist_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } alu_op_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } bist_state_e;

    localparam int NUM_VECTORS = 1024;
    localparam int VEC_IDX_W   = 10;
    localparam int ERR_COUNT_W = 11;

    // Index counts up; a and b sweep downwards, so they are the inverted low nibbles.
    function automatic logic [9:0] vec_from_idx(input logic [9:0] idx);
        return {idx[9:8], ~idx[7:4], ~idx[3:0]};
    endfunction

endpackage

// File: rtl/alu_golden_model.sv
// Combinational reference model of the 4-bit ALU under test.
module alu_golden_model
    import alu_bist_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [1:0] op,
    output logic [3:0] res,
    output logic       cout
);

    logic [4:0] sum_s;

    // Reference result and carry/borrow for each opcode.
    always_comb begin
        sum_s = {1'b0, a} + {1'b0, b};
        res   = 4'd0;
        cout  = 1'b0;
        case (alu_op_e'(op))
            OP_ADD: begin
                res  = sum_s[3:0];
                cout = sum_s[4];
            end
            OP_SUB: begin
                res  = a - b;
                cout = (a < b);
            end
            OP_AND: begin
                res  = a & b;
                cout = 1'b0;
            end
            OP_OR: begin
                res  = a | b;
                cout = 1'b0;
            end
            default: begin
                res  = 4'd0;
                cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_bist_checker.sv
// Exhaustive 1024-vector self-test sweep of a 4-bit ALU against a golden model.
// Optional build macro: ALU_BIST_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module alu_bist_checker
    import alu_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic [3:0]             alu_a,
    output logic [3:0]             alu_b,
    output logic [1:0]             alu_op,
    input  logic [3:0]             alu_res,
    input  logic                   alu_cout,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [ERR_COUNT_W-1:0] err_count,
    output logic [9:0]             first_fail
);

    bist_state_e            state_r, next_state_s;
    logic [VEC_IDX_W-1:0]   vec_idx_r;
    logic [3:0]             settle_cnt_r;
    logic [3:0]             alu_a_r, alu_b_r;
    logic [1:0]             alu_op_r;
    logic                   busy_r, done_r, pass_r;
    logic [ERR_COUNT_W-1:0] err_count_r, err_next_s;
    logic [9:0]             first_fail_r;
    logic [3:0]             gold_res_s;
    logic                   gold_cout_s;
    logic                   mismatch_s, last_vec_s, settle_last_s, start_sweep_s;

    alu_golden_model u_golden (
        .a    (alu_a_r),
        .b    (alu_b_r),
        .op   (alu_op_r),
        .res  (gold_res_s),
        .cout (gold_cout_s)
    );

    assign mismatch_s    = ({alu_cout, alu_res} != {gold_cout_s, gold_res_s});
    assign last_vec_s    = (vec_idx_r == 10'(NUM_VECTORS - 1));
    assign settle_last_s = (settle_cnt_r == 4'(SETTLE_CYCLES - 1));
    assign start_sweep_s = ((state_r == IDLE) || (state_r == DONE)) && start;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; start is only honoured while idle or finished.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (start) next_state_s = DRIVE;
                else       next_state_s = state_r;
            end
            DRIVE: next_state_s = SETTLE;
            SETTLE: begin
                if (settle_last_s) next_state_s = CHECK;
                else               next_state_s = SETTLE;
            end
            CHECK: begin
`ifdef ALU_BIST_STOP_ON_FAIL_EN
                if (mismatch_s || last_vec_s) next_state_s = DONE;
                else                          next_state_s = DRIVE;
`else
                if (last_vec_s) next_state_s = DONE;
                else            next_state_s = DRIVE;
`endif
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Error counter update, saturating at the vector count.
    always_comb begin
        err_next_s = err_count_r;
        if (start_sweep_s) begin
            err_next_s = 11'd0;
        end else if ((state_r == CHECK) && mismatch_s && (err_count_r != 11'(NUM_VECTORS))) begin
            err_next_s = err_count_r + 11'd1;
        end else begin
            err_next_s = err_count_r;
        end
    end

    // Datapath: vector index, ALU operands, settle timer, result capture and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_idx_r    <= 10'd0;
            settle_cnt_r <= 4'd0;
            alu_a_r      <= 4'd0;
            alu_b_r      <= 4'd0;
            alu_op_r     <= 2'd0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            pass_r       <= 1'b0;
            err_count_r  <= 11'd0;
            first_fail_r <= 10'd0;
        end else begin
            busy_r      <= (next_state_s == DRIVE) || (next_state_s == SETTLE) || (next_state_s == CHECK);
            done_r      <= (next_state_s == DONE);
            pass_r      <= (next_state_s == DONE) && (err_next_s == 11'd0);
            err_count_r <= err_next_s;
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        vec_idx_r    <= 10'd0;
                        first_fail_r <= 10'd0;
                    end else begin
                        vec_idx_r    <= vec_idx_r;
                    end
                end
                DRIVE: begin
                    {alu_op_r, alu_a_r, alu_b_r} <= vec_from_idx(vec_idx_r);
                    settle_cnt_r <= 4'd0;
                end
                SETTLE: settle_cnt_r <= settle_cnt_r + 4'd1;
                CHECK: begin
                    if (mismatch_s && (err_count_r == 11'd0)) begin
                        first_fail_r <= {alu_op_r, alu_a_r, alu_b_r};
                    end else begin
                        first_fail_r <= first_fail_r;
                    end
                    if (!last_vec_s) vec_idx_r <= vec_idx_r + 10'd1;
                    else             vec_idx_r <= vec_idx_r;
                end
                default: vec_idx_r <= vec_idx_r;
            endcase
        end
    end

    assign alu_a      = alu_a_r;
    assign alu_b      = alu_b_r;
    assign alu_op     = alu_op_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign pass       = pass_r;
    assign err_count  = err_count_r;
    assign first_fail = first_fail_r;

endmodule
